// File: rtl/hy_cnt_multi.sv
`default_nettype none
// ============================================================================
// Module   : hy_cnt_multi
// Purpose  : Multi-channel down-counter timer sharing one prescaler. Each
//            channel runs one-shot or periodic auto-reload. Each channel has a
//            sticky expiry flag and a masked interrupt output.
// Revision : 1.0  initial release
// ============================================================================
// The combined interrupt output is named int_out because `int` is a reserved
// SystemVerilog keyword.
module hy_cnt_multi #(
   parameter int C_WIDTH     = 32,
   parameter int C_CHAN      = 4,
   parameter int C_PSC_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [C_PSC_WIDTH-1:0]      psc_in,
   input  logic [C_CHAN-1:0]           start,
   input  logic [C_CHAN-1:0]           stop,
   input  logic [C_CHAN-1:0]           mode,
   input  logic [C_CHAN*C_WIDTH-1:0]   cnt_in,
   input  logic [C_CHAN-1:0]           int_en,
   input  logic [C_CHAN-1:0]           int_clr,
   output logic [C_CHAN*C_WIDTH-1:0]   cnt_out,
   output logic [C_CHAN-1:0]           busy,
   output logic [C_CHAN-1:0]           int_sts,
   output logic                        int_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   logic [C_PSC_WIDTH-1:0] psc_cnt_q;
   logic [C_PSC_WIDTH-1:0] psc_cnt_d;
   logic                   any_run;
   logic                   tick;

   // Shared prescaler: counts only while some channel runs, so an idle block
   // always restarts its first period from a clean zero.
   always_comb begin
      any_run   = |busy;
      tick      = 1'b0;
      psc_cnt_d = '0;
      if (any_run) begin
         if (psc_cnt_q == psc_in) begin
            tick = 1'b1;
         end else begin
            psc_cnt_d = psc_cnt_q + C_PSC_WIDTH'(1);
         end
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_cnt_q <= '0;
      end else begin
         psc_cnt_q <= psc_cnt_d;
      end
   end

   generate
      for (genvar k = 0; k < C_CHAN; k++) begin : g_chan
         state_t             state_q;
         state_t             state_d;
         logic [C_WIDTH-1:0] cnt_q;
         logic [C_WIDTH-1:0] cnt_d;
         logic               sts_q;
         logic               sts_d;
         logic               expire;
         logic [C_WIDTH-1:0] load;

         // Channel next state: stop beats start, start beats tick; an
         // expiry set beats a same-cycle clear of the sticky flag.
         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            sts_d   = sts_q;
            expire  = 1'b0;
            load    = cnt_in[k*C_WIDTH +: C_WIDTH];
            if (stop[k]) begin
               if (state_q == S_RUN) begin
                  state_d = S_IDLE;
               end
            end else if (start[k]) begin
               cnt_d   = load;
               state_d = S_RUN;
            end else if (tick && (state_q == S_RUN)) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - C_WIDTH'(1);
               end else begin
                  expire = 1'b1;
                  if (mode[k]) begin
                     cnt_d = load;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
            if (expire) begin
               sts_d = 1'b1;
            end else if (int_clr[k]) begin
               sts_d = 1'b0;
            end
         end

         // Channel state, count and sticky status registers.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               sts_q   <= 1'b0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
               sts_q   <= sts_d;
            end
         end

         assign cnt_out[k*C_WIDTH +: C_WIDTH] = cnt_q;
         assign busy[k]                       = (state_q == S_RUN);
         assign int_sts[k]                    = sts_q;
      end
   endgenerate

   assign int_out = |(int_sts & int_en);

endmodule
`default_nettype wire

// File: tb/tb_hy_cnt_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_hy_cnt_multi
// Purpose  : Directed self-checking bench for hy_cnt_multi (default params).
// Revision : 1.0  initial release
// ============================================================================
module tb_hy_cnt_multi;

   localparam int W  = 32;
   localparam int CH = 4;
   localparam int PW = 8;

   logic              clk;
   logic              rst_n;
   logic [PW-1:0]     psc_in;
   logic [CH-1:0]     start;
   logic [CH-1:0]     stop;
   logic [CH-1:0]     mode;
   logic [CH*W-1:0]   cnt_in;
   logic [CH-1:0]     int_en;
   logic [CH-1:0]     int_clr;
   logic [CH*W-1:0]   cnt_out;
   logic [CH-1:0]     busy;
   logic [CH-1:0]     int_sts;
   logic              int_out;

   int total_cnt = 0;
   int pass_cnt  = 0;

   hy_cnt_multi #(.C_WIDTH(W), .C_CHAN(CH), .C_PSC_WIDTH(PW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .psc_in  (psc_in),
      .start   (start),
      .stop    (stop),
      .mode    (mode),
      .cnt_in  (cnt_in),
      .int_en  (int_en),
      .int_clr (int_clr),
      .cnt_out (cnt_out),
      .busy    (busy),
      .int_sts (int_sts),
      .int_out (int_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] cnt_of(input int k);
      return cnt_out[k*W +: W];
   endfunction

   initial begin
      rst_n   = 1'b0;
      psc_in  = '0;
      start   = '0;
      stop    = '0;
      mode    = '0;
      cnt_in  = '0;
      int_en  = '0;
      int_clr = '0;
      step(3);
      chk("rst_cnt",  64'(cnt_out), 64'h0);
      chk("rst_busy", 64'(busy),    64'h0);
      chk("rst_sts",  64'(int_sts), 64'h0);
      chk("rst_int",  64'(int_out), 64'h0);
      rst_n = 1'b1;
      step(2);

      // ch0 one-shot, psc 0, load 0xA5
      int_en          = 4'b0001;
      cnt_in[0*W +: W] = 32'hA5;
      start           = 4'b0001;
      step(1);
      start = '0;
      chk("os_load",  64'(cnt_of(0)), 64'hA5);
      chk("os_busy",  64'(busy),      64'h1);
      step(1);
      chk("os_dec1",  64'(cnt_of(0)), 64'hA4);
      step(164);
      chk("os_zero",  64'(cnt_of(0)), 64'h0);
      chk("os_nosts", 64'(int_sts),   64'h0);
      step(1);
      chk("os_sts",   64'(int_sts),   64'h1);
      chk("os_int",   64'(int_out),   64'h1);
      chk("os_done",  64'(busy),      64'h0);
      step(3);
      chk("os_hold",  64'(cnt_of(0)), 64'h0);
      int_clr = 4'b0001;
      step(1);
      int_clr = '0;
      chk("os_clr",   64'(int_sts),   64'h0);
      chk("os_clri",  64'(int_out),   64'h0);

      // ch1 periodic, psc 3, load 2 -> expiry every 12 clocks
      psc_in           = 8'd3;
      mode             = 4'b0010;
      cnt_in[1*W +: W] = 32'd2;
      start            = 4'b0010;
      step(1);
      start = '0;
      chk("per_load", 64'(cnt_of(1)), 64'd2);
      step(4);
      chk("per_c1",   64'(cnt_of(1)), 64'd1);
      step(4);
      chk("per_c0",   64'(cnt_of(1)), 64'd0);
      step(3);
      chk("per_pre",  64'(int_sts),   64'h0);
      step(1);
      chk("per_sts1", 64'(int_sts),   64'h2);
      chk("per_rld1", 64'(cnt_of(1)), 64'd2);
      chk("per_run",  64'(busy),      64'h2);
      chk("per_mask", 64'(int_out),   64'h0);
      step(1);
      int_clr = 4'b0010;
      step(1);
      int_clr = '0;
      chk("per_clr1", 64'(int_sts),   64'h0);
      step(9);
      chk("per_pre2", 64'(int_sts),   64'h0);
      step(1);
      chk("per_sts2", 64'(int_sts),   64'h2);
      step(1);
      int_clr = 4'b0010;
      step(1);
      int_clr = '0;
      chk("per_clr2", 64'(int_sts),   64'h0);
      step(9);
      int_clr = 4'b0010;
      step(1);
      int_clr = '0;
      chk("per_setwin", 64'(int_sts),   64'h2);
      chk("per_rld3",   64'(cnt_of(1)), 64'd2);
      stop = 4'b0010;
      step(1);
      stop = '0;
      chk("per_stop",  64'(busy),      64'h0);
      chk("per_held",  64'(cnt_of(1)), 64'd2);
      int_clr = 4'b0010;
      step(1);
      int_clr = '0;

      // ch2 stop+start same cycle
      psc_in           = 8'd0;
      mode             = 4'b0000;
      cnt_in[2*W +: W] = 32'd10;
      start            = 4'b0100;
      step(1);
      start = '0;
      step(3);
      chk("ss_run",    64'(cnt_of(2)), 64'd7);
      cnt_in[2*W +: W] = 32'd50;
      stop             = 4'b0100;
      start            = 4'b0100;
      step(1);
      stop  = '0;
      start = '0;
      chk("ss_idle",   64'(busy),      64'h0);
      chk("ss_hold",   64'(cnt_of(2)), 64'd7);
      step(2);
      chk("ss_hold2",  64'(cnt_of(2)), 64'd7);
      start = 4'b0100;
      step(1);
      start = '0;
      chk("ss_reload", 64'(cnt_of(2)), 64'd50);
      step(1);
      chk("ss_dec",    64'(cnt_of(2)), 64'd49);
      stop = 4'b0100;
      step(1);
      stop = '0;

      // all four channels, psc 1, int_en 0101
      psc_in           = 8'd1;
      int_en           = 4'b0101;
      cnt_in[0*W +: W] = 32'd1;
      cnt_in[1*W +: W] = 32'd2;
      cnt_in[2*W +: W] = 32'd3;
      cnt_in[3*W +: W] = 32'd4;
      start            = 4'b1111;
      step(1);
      start = '0;
      chk("all_busy", 64'(busy),    64'hF);
      step(4);
      chk("all_s0",   64'(int_sts), 64'h1);
      chk("all_i0",   64'(int_out), 64'h1);
      int_clr = 4'b0001;
      step(1);
      int_clr = '0;
      chk("all_c0",   64'(int_sts), 64'h0);
      step(1);
      chk("all_s1",   64'(int_sts), 64'h2);
      chk("all_i1",   64'(int_out), 64'h0);
      step(2);
      chk("all_s2",   64'(int_sts), 64'h6);
      chk("all_i2",   64'(int_out), 64'h1);
      step(2);
      chk("all_s3",   64'(int_sts), 64'hE);
      chk("all_idle", 64'(busy),    64'h0);

      // asynchronous reset mid-count
      psc_in           = 8'd0;
      int_en           = 4'b1111;
      mode             = 4'b0001;
      cnt_in[0*W +: W] = 32'd100;
      start            = 4'b0001;
      step(1);
      start = '0;
      step(5);
      chk("ar_pre",   64'(cnt_of(0)), 64'd95);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_cnt",   64'(cnt_out), 64'h0);
      chk("ar_busy",  64'(busy),    64'h0);
      chk("ar_sts",   64'(int_sts), 64'h0);
      chk("ar_int",   64'(int_out), 64'h0);
      #2;
      rst_n = 1'b1;
      step(20);
      chk("ar_post_cnt",  64'(cnt_out), 64'h0);
      chk("ar_post_busy", 64'(busy),    64'h0);
      chk("ar_post_int",  64'(int_out), 64'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hy_cnt_multi.md
HY_CNT_MULTI -- requirements
Module: hy_cnt_multi

Interface
REQ-001 The module SHALL have parameter C_WIDTH, default 32, giving the counter width in bits per channel.
REQ-002 The module SHALL have parameter C_CHAN, default 4, giving the number of independent channels (range 1-16).
REQ-003 The module SHALL have parameter C_PSC_WIDTH, default 8, giving the shared prescaler width.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port psc_in, input, C_PSC_WIDTH bits: a tick fires every psc_in+1 clocks.
REQ-007 The module SHALL have port start, input, C_CHAN bits: per-channel load-and-run strobe, 1-cycle pulse.
REQ-008 The module SHALL have port stop, input, C_CHAN bits: per-channel halt strobe.
REQ-009 The module SHALL have port mode, input, C_CHAN bits: per-channel mode, 0 = one-shot, 1 = periodic auto-reload.
REQ-010 The module SHALL have port cnt_in, input, C_CHAN*C_WIDTH bits: per-channel load value; channel k uses bits [k*C_WIDTH +: C_WIDTH].
REQ-011 The module SHALL have port int_en, input, C_CHAN bits: per-channel interrupt enable.
REQ-012 The module SHALL have port int_clr, input, C_CHAN bits: per-channel clear for the sticky status.
REQ-013 The module SHALL have port cnt_out, output, C_CHAN*C_WIDTH bits: per-channel current count, registered.
REQ-014 The module SHALL have port busy, output, C_CHAN bits: 1 while the channel is in RUN.
REQ-015 The module SHALL have port int_sts, output, C_CHAN bits: per-channel sticky expiry flag, registered.
REQ-016 The module SHALL have port int, output, 1 bit: OR over k of (int_sts[k] & int_en[k]), combinational.

Function
REQ-017 Each channel SHALL implement states IDLE, RUN and DONE; busy[k] = (state == RUN).
REQ-018 Prescaler: psc_cnt SHALL increment each clock while any channel is in RUN; when psc_cnt == psc_in it SHALL assert tick for that cycle and return to 0; psc_in = 0 gives a tick every cycle.
REQ-019 psc_cnt SHALL be forced to 0 in any cycle where no channel is in RUN; a psc_in change SHALL apply at the next compare.
REQ-020 Per-channel priority SHALL be stop > start > tick.
REQ-021 stop in RUN: go to IDLE, hold cnt_out; stop in IDLE or DONE: no effect.
REQ-022 start in any state: cnt_out <= cnt_in slice, state <= RUN, visible on the next cycle; no decrement in the start cycle.
REQ-023 tick in RUN with cnt != 0: cnt <= cnt - 1.
REQ-024 tick in RUN with cnt == 0 (expiry): set int_sts[k] on the next cycle; one-shot goes to DONE with cnt held at 0; periodic reloads cnt from the current cnt_in slice and stays in RUN.
REQ-025 The count SHALL never wrap below 0; a reload value of 0 expires on every tick in periodic mode.
REQ-026 A period SHALL therefore be (cnt_in+1) ticks = (cnt_in+1)*(psc_in+1) clocks.
REQ-027 If int_clr[k] and an expiry occur in the same cycle, set SHALL win; otherwise int_clr[k] clears int_sts[k].
REQ-028 int_sts SHALL set regardless of int_en; int_en masks only int.
REQ-029 mode SHALL be sampled at each expiry, so a mode change takes effect at the next expiry.

Reset
REQ-030 While rst_n = 0, all outputs SHALL be 0: cnt_out, busy, int_sts, int, psc_cnt = 0 and all channels in IDLE, independent of clk.
REQ-031 Reset asserted mid-RUN SHALL abort immediately, and no int SHALL be produced after release until a new start.

Verification
REQ-032 Scenario: psc_in = 0, ch0 one-shot, cnt_in = 0xA5, int_en = 1, start pulse at edge T -> cnt_out 0xA5 at T+1, 0 at T+166, int_sts[0] and int = 1 at T+167, busy 0, cnt held at 0.
REQ-033 Scenario: psc_in = 3, ch1 periodic, cnt_in = 2 -> int_sts[1] sets every 12 clocks; int_clr pulses between expiries clear it; cnt sequence is 2,1,0,2,...
REQ-034 Scenario: int_clr[1] coincident with an expiry -> int_sts[1] remains 1.
REQ-035 Scenario: stop and start on ch2 in the same cycle -> IDLE, cnt unchanged; a later start alone reloads and runs.
REQ-036 Scenario: all four channels run with different cnt_in and int_en = 4'b0101 -> int follows only ch0 and ch2, while int_sts shows all four.
REQ-037 Scenario: rst_n low for 3 ns mid-count, asynchronous to clk -> all outputs are 0 immediately, and no activity occurs after release.
